// File: rtl/hwag_ssram_bank.sv
// Register bank on a bidirectional SSRAM-style bus, one register per address.
// Define HWAG_SSRAM_SHADOW_EN for double-buffered (shadow + commit) mode.

module hwag_ssram_reg #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              commit,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_q,
    output logic [DATA_W-1:0] act_q
);
`ifdef HWAG_SSRAM_SHADOW_EN
    logic [DATA_W-1:0] shadow;

    always_ff @(posedge clk) begin
        if (!rst) begin
            shadow <= '0;
            act_q  <= '0;
        end else begin
            if (wr_en)
                shadow <= wr_data;
            // a write landing on the commit edge goes straight through to active
            if (commit)
                act_q <= wr_en ? wr_data : shadow;
        end
    end

    assign rd_q = shadow;
`else
    wire unused_commit = commit;

    always_ff @(posedge clk) begin
        if (!rst)
            act_q <= '0;
        else if (wr_en)
            act_q <= wr_data;
    end

    assign rd_q = act_q;
`endif
endmodule

module hwag_ssram_bank #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ssram_we,
    input  logic                    ssram_re,
    input  logic [ADDR_W-1:0]       ssram_addr,
    inout  wire  [DATA_W-1:0]       ssram_data,
    input  logic                    commit,
    output logic [DEPTH*DATA_W-1:0] ssram_out,
    output logic                    rd_valid,
    output logic                    addr_err
);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    logic                          in_range;
    logic                          wr_acc;
    logic                          rd_acc;
    logic [DEPTH-1:0]              wr_sel;
    logic [DEPTH-1:0][DATA_W-1:0]  rd_q;
    logic [DEPTH-1:0][DATA_W-1:0]  act_q;
    logic [DATA_W-1:0]             rd_mux;
    logic [DATA_W-1:0]             rd_data;

    // widened compare so addresses past DEPTH never alias onto a register
    assign in_range = {1'b0, ssram_addr} < DEPTH_L;
    assign wr_acc   = ssram_we && in_range;
    assign rd_acc   = ssram_re && !ssram_we;

    for (genvar i = 0; i < DEPTH; i++) begin : g_reg
        assign wr_sel[i] = wr_acc && (ssram_addr == ADDR_W'(i));

        hwag_ssram_reg #(.DATA_W(DATA_W)) u_reg (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (wr_sel[i]),
            .commit  (commit),
            .wr_data (ssram_data),
            .rd_q    (rd_q[i]),
            .act_q   (act_q[i])
        );
    end

    assign ssram_out = act_q;

    // no match for out-of-range addresses leaves the mux at zero
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < DEPTH; i++)
            if (ssram_addr == ADDR_W'(i))
                rd_mux = rd_q[i];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
            addr_err <= 1'b0;
        end else begin
            rd_valid <= rd_acc;
            if (rd_acc)
                rd_data <= rd_mux;
            addr_err <= (ssram_we || ssram_re) && !in_range;
        end
    end

    assign ssram_data = rd_valid ? rd_data : {DATA_W{1'bz}};
endmodule

// File: tb/tb_hwag_ssram_bank.sv
// Directed bench for hwag_ssram_bank: behavioural bank model checked every cycle
// plus literal checks on the key scenarios.

module tb_hwag_ssram_bank;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 64;
`ifdef HWAG_SSRAM_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic we = 1'b0, re = 1'b0, commit = 1'b0;
    logic [ADDR_W-1:0] addr = '0;
    logic [DATA_W-1:0] drv = '0;
    logic drv_en = 1'b0;
    wire  [DATA_W-1:0] ssram_data;
    logic [DEPTH*DATA_W-1:0] ssram_out;
    logic rd_valid, addr_err;

    assign ssram_data = drv_en ? drv : {DATA_W{1'bz}};

    hwag_ssram_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .ssram_we   (we),
        .ssram_re   (re),
        .ssram_addr (addr),
        .ssram_data (ssram_data),
        .commit     (commit),
        .ssram_out  (ssram_out),
        .rd_valid   (rd_valid),
        .addr_err   (addr_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got %0h exp %0h", name, got, exp);
    endtask

    function automatic logic [DATA_W-1:0] out_reg(input int i);
        return ssram_out[i*DATA_W +: DATA_W];
    endfunction

    // model: bank contents and the outputs expected after each edge
    logic [DATA_W-1:0] m_sh  [DEPTH];
    logic [DATA_W-1:0] m_act [DEPTH];
    logic              e_vld = 1'b0, e_err = 1'b0, model_ok = 1'b0;
    logic [DATA_W-1:0] e_rd = '0;

    always @(posedge clk) begin
        int a;
        bit inr;
        a   = int'(addr);
        inr = a < DEPTH;
        model_ok = 1'b1;
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_sh[i]  = '0;
                m_act[i] = '0;
            end
            e_vld = 1'b0;
            e_err = 1'b0;
        end else begin
            e_err = (we || re) && !inr;
            e_vld = re && !we;
            if (e_vld)
                e_rd = !inr ? '0 : (SHADOW ? m_sh[a] : m_act[a]);
            if (we && inr) begin
                if (SHADOW) m_sh[a] = drv;
                else        m_act[a] = drv;
            end
            if (SHADOW && commit)
                for (int i = 0; i < DEPTH; i++) m_act[i] = m_sh[i];
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            chk("rd_valid", rd_valid, e_vld);
            chk("addr_err", addr_err, e_err);
            if (e_vld) chk("rd_data", ssram_data, e_rd);
            for (int i = 0; i < DEPTH; i++)
                if (out_reg(i) !== m_act[i]) begin
                    chk($sformatf("ssram_out[%0d]", i), out_reg(i), m_act[i]);
                    break;
                end
        end
    end

    task automatic cyc(input logic w, input logic r, input int a,
                       input logic [DATA_W-1:0] d, input logic cm);
        we = w; re = r; addr = ADDR_W'(a); drv = d; drv_en = w; commit = cm;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 0, '0, 1'b0);
    endtask

    initial begin
        rst = 1'b0;
        idle();
        idle();
        chk("reset_rd_valid", rd_valid, 1'b0);
        chk("reset_addr_err", addr_err, 1'b0);
        chk("reset_out_zero", 64'(ssram_out != '0), 64'd0);

        rst = 1'b1;
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b0, i, DATA_W'(2*i), 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            cyc(1'b0, 1'b1, i, '0, 1'b0);
            if (i == 10 || i == 63) begin
                chk($sformatf("b2b_vld_%0d", i), rd_valid, 1'b1);
                chk($sformatf("b2b_data_%0d", i), ssram_data, 64'(2*i));
            end
        end
        idle();

        cyc(1'b1, 1'b0, 5, 16'h1234, 1'b0);
        idle();
        chk("reg5_pre_commit", out_reg(5), SHADOW ? 16'h0000 : 16'h1234);
        cyc(1'b0, 1'b0, 0, '0, 1'b1);
        chk("reg5_post_commit", out_reg(5), 16'h1234);

        cyc(1'b1, 1'b1, 3, 16'hBEEF, 1'b0);
        chk("we_re_no_valid", rd_valid, 1'b0);
        cyc(1'b0, 1'b1, 3, '0, 1'b0);
        chk("read_after_write", ssram_data, 16'hBEEF);
        idle();

        cyc(1'b1, 1'b0, 64, 16'hFFFF, 1'b0);
        chk("wr64_err", addr_err, 1'b1);
        idle();
        chk("err_one_cycle", addr_err, 1'b0);
        cyc(1'b1, 1'b0, 255, 16'hFFFF, 1'b0);
        chk("wr255_err", addr_err, 1'b1);
        cyc(1'b0, 1'b1, 255, '0, 1'b0);
        chk("rd255_err", addr_err, 1'b1);
        chk("rd255_vld", rd_valid, 1'b1);
        chk("rd255_zero", ssram_data, 16'h0000);
        cyc(1'b0, 1'b1, 64, '0, 1'b0);
        chk("rd64_zero", ssram_data, 16'h0000);
        idle();

        cyc(1'b1, 1'b0, 7, 16'h00AA, 1'b1);
        chk("commit_write_through", out_reg(7), 16'h00AA);
        idle();

        cyc(1'b0, 1'b1, 9, '0, 1'b0);
        chk("pre_reset_vld", rd_valid, 1'b1);
        rst = 1'b0;
        cyc(1'b0, 1'b1, 9, '0, 1'b1);
        chk("mid_read_reset_vld", rd_valid, 1'b0);
        chk("mid_read_reset_out", 64'(ssram_out != '0), 64'd0);

        rst = 1'b1;
        cyc(1'b1, 1'b0, 1, 16'h0055, 1'b1);
        cyc(1'b0, 1'b1, 1, '0, 1'b0);
        chk("first_edge_write", ssram_data, 16'h0055);
        idle();
        idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
